// File: rtl/posit_round_encode_pipe_if.sv
// Handshake and data bundle for posit_round_encode_pipe.
//
// Signals:
//   in_valid / in_ready   : upstream handshake for one unpacked posit
//   in_sign, in_isZero,
//   in_isInf              : unpacked flags
//   in_exponent           : biased exponent (value - MAXEXP = signed exponent)
//   in_fraction           : fraction bits below the hidden one
//   in_trailing           : guard/round bits below in_fraction, MSB first
//   in_sticky             : OR of everything below in_trailing
//   out_valid / out_ready : downstream handshake
//   out_posit             : packed, rounded posit
//
// Handshake rule, identical on both ports: a word moves on a rising clock
// edge where valid and ready are both high. A producer holding valid high
// keeps its data stable until that edge; ready may depend combinationally
// on the consumer side but valid never depends on ready.
//
// Modports: master = the upstream producer / downstream consumer side
// (the bench), slave = the encoder.
interface posit_round_encode_pipe_if #(
  parameter int POSIT_WIDTH   = 8,
  parameter int POSIT_ES      = 1,
  parameter int TRAILING_BITS = 2
);
  localparam int FRAC_BITS = POSIT_WIDTH - 3 - POSIT_ES;
  localparam int MAXEXP    = (POSIT_WIDTH - 2) * (2 ** POSIT_ES);
  localparam int UEXP_BITS = $clog2(2 * MAXEXP + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sign;
  logic                     in_isZero;
  logic                     in_isInf;
  logic [UEXP_BITS-1:0]     in_exponent;
  logic [FRAC_BITS-1:0]     in_fraction;
  logic [TRAILING_BITS-1:0] in_trailing;
  logic                     in_sticky;
  logic                     out_valid;
  logic                     out_ready;
  logic [POSIT_WIDTH-1:0]   out_posit;

  modport slave (
    input  in_valid, in_sign, in_isZero, in_isInf, in_exponent,
    input  in_fraction, in_trailing, in_sticky, out_ready,
    output in_ready, out_valid, out_posit
  );

  modport master (
    output in_valid, in_sign, in_isZero, in_isInf, in_exponent,
    output in_fraction, in_trailing, in_sticky, out_ready,
    input  in_ready, out_valid, out_posit
  );
endinterface

// File: rtl/posit_round_encode_pipe.sv
// Two-stage posit encoder: takes an unpacked posit (sign, biased exponent,
// fraction plus guard/sticky bits) and produces the packed, rounded
// (round-to-nearest-even) N-bit posit.
//   S1: build the regime/es/fraction body and split it into kept bits,
//       guard bit and sticky.
//   S2: round, clamp to [minpos, maxpos], apply sign, handle zero/NaR.
//
// Ports:
//   clock  : sole clock, rising edge
//   resetn : asynchronous active-low reset (clears both stage valids)
//   bus    : posit_round_encode_pipe_if.slave handshake/data bundle
//
// Assumes POSIT_ES >= 1.
module posit_round_encode_pipe #(
  parameter int POSIT_WIDTH   = 8,
  parameter int POSIT_ES      = 1,
  parameter int TRAILING_BITS = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  posit_round_encode_pipe_if.slave      bus
);
  localparam int N         = POSIT_WIDTH;
  localparam int ES        = POSIT_ES;
  localparam int FRAC_BITS = N - 3 - ES;
  localparam int MAXEXP    = (N - 2) * (2 ** ES);
  localparam int UEXP_BITS = $clog2(2 * MAXEXP + 1);
  // Everything that can follow the regime: es, fraction, trailing, sticky.
  localparam int TAIL_W    = ES + FRAC_BITS + TRAILING_BITS + 1;
  // Two seed regime bits, the tail, and N zero bits of headroom so the
  // regime shift never pushes a set bit off the bottom.
  localparam int VW        = 2 + TAIL_W + N;

  localparam logic signed [UEXP_BITS:0] BIAS_S  = (UEXP_BITS+1)'(MAXEXP);
  localparam logic [UEXP_BITS-1:0]      EXP_TOP = UEXP_BITS'(2 * MAXEXP);
  localparam logic [N-1:0]              MAXPOS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]              MINPOS  = N'(1);
  localparam logic [N-1:0]              NAR     = {1'b1, {(N-1){1'b0}}};

  // ---------------- pipeline control ----------------
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // ---------------- S1: regime build / align ----------------
  logic signed [UEXP_BITS:0] e_val;
  logic signed [UEXP_BITS:0] k_val;
  logic        [UEXP_BITS:0] shift_amt;
  logic        [VW-1:0]      seed;
  logic        [VW-1:0]      shifted;

  always_comb begin
    e_val = $signed({1'b0, bus.in_exponent}) - BIAS_S;
    k_val = e_val >>> ES;
    // k >= 0: seed "10" and replicate the leading 1 k times.
    // k <  0: seed "01" and replicate the leading 0 (-k-1) times; ~k == -k-1.
    shift_amt = k_val[UEXP_BITS] ? ~k_val : k_val;
    seed = {(k_val[UEXP_BITS] ? 2'b01 : 2'b10), e_val[ES-1:0], bus.in_fraction,
            bus.in_trailing, bus.in_sticky, {N{1'b0}}};
    shifted = VW'($signed(seed) >>> shift_amt);
  end

  logic [N-2:0] s1_body;
  logic         s1_guard;
  logic         s1_sticky;
  logic         s1_sign;
  logic         s1_inf;
  logic         s1_zero;
  logic         s1_sat;

  always_ff @(posedge clock) begin
    if (s1_load && bus.in_valid) begin
      s1_body   <= shifted[VW-1 -: N-1];
      s1_guard  <= shifted[VW-N];
      s1_sticky <= |shifted[VW-N-1:0];
      s1_sign   <= bus.in_sign;
      s1_inf    <= bus.in_isInf;
      s1_zero   <= bus.in_isZero;
      s1_sat    <= bus.in_exponent > EXP_TOP;
    end
  end

  // ---------------- S2: round / clamp / negate ----------------
  logic         round_inc;
  logic [N-1:0] mag_sum;
  logic [N-1:0] mag;
  logic [N-1:0] result;

  always_comb begin
    round_inc = s1_guard && (s1_sticky || s1_body[0]);
    mag_sum   = {1'b0, s1_body} + {{(N-1){1'b0}}, round_inc};
    // Carry into the sign position means rounding past maxpos; a finite
    // nonzero value must never collapse to zero either.
    if (s1_sat || mag_sum[N-1]) mag = MAXPOS;
    else if (mag_sum == '0)     mag = MINPOS;
    else                        mag = mag_sum;
    if (s1_inf)       result = NAR;
    else if (s1_zero) result = '0;
    else if (s1_sign) result = -mag;
    else              result = mag;
  end

  logic [N-1:0] out_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_q    <= '0;
    end else begin
      if (s1_load) s1_valid <= bus.in_valid;
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) out_q <= result;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_posit = out_q;
endmodule

// File: tb/tb_posit_round_encode_pipe.sv
module tb_posit_round_encode_pipe;
  logic clock = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  posit_round_encode_pipe_if bus ();

  posit_round_encode_pipe dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_accepted = 0;
  logic [7:0] exp_q[$];
  bit rand_ready = 0;

  // Reference encoder: writes the posit body out bit by bit, then rounds.
  function automatic logic [7:0] ref_posit(input logic s, input logic z, input logic inf,
                                           input logic [4:0] ex, input logic [3:0] fr,
                                           input logic [1:0] tr, input logic st);
    int e, k, es, mag;
    bit bits[$];
    bit g, sr;
    if (inf) return 8'h80;
    if (z) return 8'h00;
    if (ex > 24) mag = 127;
    else begin
      e = int'(ex) - 12;
      if (e >= 0) k = e / 2;
      else k = -((1 - e) / 2);
      es = e - 2 * k;
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(es[0]);
      for (int i = 3; i >= 0; i--) bits.push_back(fr[i]);
      bits.push_back(tr[1]);
      bits.push_back(tr[0]);
      bits.push_back(st);
      mag = 0;
      for (int i = 0; i < 7; i++) mag = mag * 2 + int'(bits[i]);
      g = bits[7];
      sr = 1'b0;
      for (int i = 8; i < bits.size(); i++) sr = sr | bits[i];
      if (g && (sr || (mag % 2 == 1))) mag++;
      if (mag > 127) mag = 127;
      if (mag == 0) mag = 1;
    end
    return s ? 8'(256 - mag) : 8'(mag);
  endfunction

  // Scoreboard: expectations queued on input transfer, checked on output transfer.
  always @(negedge clock) begin
    logic [7:0] want;
    if (!resetn) exp_q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_output observed=%h required=no output", bus.out_posit);
        end
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          n_checks++;
          assert (bus.out_posit === want) else begin
            n_fail++;
            $error("FAIL out_posit observed=%h required=%h", bus.out_posit, want);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_posit(bus.in_sign, bus.in_isZero, bus.in_isInf, bus.in_exponent,
                                  bus.in_fraction, bus.in_trailing, bus.in_sticky));
        n_accepted++;
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_fields(input logic s, input logic z, input logic inf, input logic [4:0] ex,
                            input logic [3:0] fr, input logic [1:0] tr, input logic st);
    bus.in_sign = s;
    bus.in_isZero = z;
    bus.in_isInf = inf;
    bus.in_exponent = ex;
    bus.in_fraction = fr;
    bus.in_trailing = tr;
    bus.in_sticky = st;
  endtask

  // Drive one word and hold it until accepted; returns at posedge+1 after the transfer.
  task automatic send(input logic s, input logic z, input logic inf, input logic [4:0] ex,
                      input logic [3:0] fr, input logic [1:0] tr, input logic st);
    int guard_cnt;
    set_fields(s, z, inf, ex, fr, tr, st);
    bus.in_valid = 1'b1;
    guard_cnt = 0;
    forever begin
      @(negedge clock);
      if (bus.in_ready) break;
      guard_cnt++;
      if (guard_cnt > 200) begin
        n_checks++;
        n_fail++;
        $error("FAIL send_timeout observed=in_ready low required=accept within 200 cycles");
        break;
      end
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed=%0d pending required=0", exp_q.size());
    end
  endtask

  initial begin
    int lat;
    int acc0;
    logic [7:0] held;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_fields(0, 0, 0, 5'd12, 4'd0, 2'd0, 0);

    // Reset values
    #2;
    n_checks++;
    assert (bus.out_valid === 1'b0) else begin n_fail++; $error("FAIL reset_out_valid observed=%b required=0", bus.out_valid); end
    n_checks++;
    assert (bus.in_ready === 1'b1) else begin n_fail++; $error("FAIL reset_in_ready observed=%b required=1", bus.in_ready); end
    n_checks++;
    assert (bus.out_posit === 8'h00) else begin n_fail++; $error("FAIL reset_out_posit observed=%h required=00", bus.out_posit); end
    #21;
    resetn = 1'b1;
    idle(2);

    // Latency: 1.0 -> 0x40, output two cycles after the accepting cycle
    send(0, 0, 0, 5'd12, 4'b0000, 2'b00, 0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    n_checks++;
    assert (lat == 2) else begin n_fail++; $error("FAIL latency observed=%0d required=2", lat); end
    n_checks++;
    assert (bus.out_posit === 8'h40) else begin n_fail++; $error("FAIL one_direct observed=%h required=40", bus.out_posit); end
    drain();

    // Directed encodings
    send(1, 0, 0, 5'd12, 4'b0000, 2'b00, 0);  // -1.0 -> C0
    send(0, 0, 0, 5'd12, 4'b0001, 2'b10, 0);  // tie, odd -> 42
    send(0, 0, 0, 5'd12, 4'b0000, 2'b10, 0);  // tie, even -> 40
    send(0, 0, 0, 5'd12, 4'b0000, 2'b10, 1);  // above tie -> 41
    send(0, 0, 0, 5'd24, 4'b1111, 2'b11, 1);  // maxpos 7F
    send(0, 0, 0, 5'd0,  4'b0000, 2'b00, 0);  // minpos 01
    send(0, 0, 1, 5'd12, 4'b1010, 2'b01, 1);  // NaR 80
    send(1, 1, 0, 5'd12, 4'b1010, 2'b01, 1);  // zero 00
    send(0, 1, 1, 5'd3,  4'b0000, 2'b00, 0);  // inf beats zero -> 80
    send(0, 0, 0, 5'd30, 4'b0000, 2'b00, 0);  // exponent out of range -> 7F
    send(1, 0, 0, 5'd0,  4'b0000, 2'b00, 0);  // -minpos FF
    drain();

    // Backpressure: stream in with out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    acc0 = n_accepted;
    held = 8'h00;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_fields(i[0], 0, 0, 5'(8 + i), 4'(3 * i), 2'(i), 0);
      @(posedge clock);
      #1;
      if (i == 1) held = bus.out_posit;
      if (i >= 2) begin
        n_checks++;
        assert (bus.out_posit === held) else begin n_fail++; $error("FAIL stall_stable observed=%h required=%h", bus.out_posit, held); end
        n_checks++;
        assert (bus.out_valid === 1'b1) else begin n_fail++; $error("FAIL stall_valid observed=%b required=1", bus.out_valid); end
      end
    end
    n_checks++;
    assert (n_accepted - acc0 == 2) else begin n_fail++; $error("FAIL stall_accepted observed=%0d required=2", n_accepted - acc0); end
    n_checks++;
    assert (bus.in_ready === 1'b0) else begin n_fail++; $error("FAIL stall_in_ready observed=%b required=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(1, 0, 0, 5'(14 + i), 4'(5 * i + 1), 2'(3 - i), 1'(i));
      n_checks++;
      assert (bus.out_valid === 1'b1) else begin n_fail++; $error("FAIL no_bubble observed=%b required=1", bus.out_valid); end
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(0, 0, 0, 5'd20, 4'b0101, 2'b01, 0);
    send(1, 0, 0, 5'd4,  4'b1100, 2'b10, 1);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    assert (bus.out_valid === 1'b0) else begin n_fail++; $error("FAIL reset_mid_valid observed=%b required=0", bus.out_valid); end
    n_checks++;
    assert (bus.in_ready === 1'b1) else begin n_fail++; $error("FAIL reset_mid_ready observed=%b required=1", bus.in_ready); end
    idle(2);
    #2;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    acc0 = n_accepted;
    send(0, 0, 0, 5'd13, 4'b0011, 2'b11, 0);
    drain();
    n_checks++;
    assert (n_accepted - acc0 == 1) else begin n_fail++; $error("FAIL post_reset_accept observed=%0d required=1", n_accepted - acc0); end

    // Randomized stream with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      send(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    #1;
    bus.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/posit_round_encode_pipe.md
POSIT_ROUND_ENCODE_PIPE -- requirements
Module: posit_round_encode_pipe

Interface
REQ-001 Parameter POSIT_WIDTH, default 8, total posit bits N.
REQ-002 Parameter POSIT_ES, default 1, exponent field bits ES.
REQ-003 Parameter TRAILING_BITS, default 2, guard/round bits supplied by the producing stage.
REQ-004 Derived: FRAC_BITS = N-3-ES (4); MAXEXP = (N-2)*2^ES (12); BIAS = MAXEXP; UEXP_BITS = clog2(2*MAXEXP+1) (5).
REQ-005 clock  input  1  sole clock; all state on rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream unpacked posit valid.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 in_sign, in_isZero, in_isInf  input  1 each  unpacked flags.
REQ-010 in_exponent  input  UEXP_BITS  biased exponent (value - BIAS = signed exponent e), range 0..2*MAXEXP.
REQ-011 in_fraction  input  FRAC_BITS  fraction below hidden 1.
REQ-012 in_trailing  input  TRAILING_BITS  bits directly below in_fraction LSB, MSB first.
REQ-013 in_sticky  input  1  OR of all bits below in_trailing.
REQ-014 out_valid  output  1  out_posit valid.
REQ-015 out_ready  input  1  downstream accepts.
REQ-016 out_posit  output  N  packed, rounded posit.

Function
REQ-017 Transfer occurs on a cycle where valid and ready are both high, on each port independently.
REQ-018 Two register stages S1 (regime build/align) and S2 (round/negate); latency exactly 2 cycles from input transfer to out_valid when out_ready held high; throughput 1 per cycle.
REQ-019 Stage advance: S2 loads when S2 empty or out_ready; S1 loads when S1 empty or S2 loads; in_ready = S1 empty or S2 loads (combinational from out_ready, no bubble).
REQ-020 While out_valid high and out_ready low, out_posit and out_valid SHALL hold stable.
REQ-021 Encoding (S1): k = floor(e / 2^ES), es = e mod 2^ES; regime = (k+1) ones then a zero for k>=0, (-k) zeros then a one for k<0; body = regime, es, in_fraction, in_trailing, in_sticky, truncated to N-1 bits after the sign position.
REQ-022 Rounding (S2): round-to-nearest-even; guard = first dropped body bit, sticky = OR of all later dropped bits including in_sticky; increment when guard and (sticky or kept LSB).
REQ-023 Saturation: a finite nonzero input SHALL never produce 0 or NaR; magnitude clamps to maxpos (0x7F for N=8) on overflow and to minpos (0x01) on underflow to zero.
REQ-024 Sign: in_sign=1 SHALL produce two's complement of the rounded positive magnitude over N bits.
REQ-025 Special: in_isInf=1 -> 1 followed by N-1 zeros (0x80) regardless of other fields; else in_isZero=1 -> all zeros; isInf takes priority over isZero.
REQ-026 in_exponent above 2*MAXEXP SHALL be treated as maxpos magnitude.
REQ-027 Simultaneous input and output transfer with both stages full SHALL shift the pipeline with no loss or duplication.

Reset
REQ-028 resetn low SHALL asynchronously clear both stage valid flags; out_valid=0, out_posit=0, in_ready=1 during reset.
REQ-029 Reset mid-operation discards in-flight data; first output after release derives from the first post-release transfer.
REQ-030 Data registers need no reset except the S2 value feeding out_posit.

Verification
REQ-031 e=0 (exp 12), frac 0000, trail 00, sticky 0, sign 0 -> 0x40 two cycles later; same with sign 1 -> 0xC0.
REQ-032 e=0, frac 0001, trail 10, sticky 0 -> 0x42 (tie, odd LSB up); frac 0000, trail 10, sticky 0 -> 0x40; sticky 1 -> 0x41.
REQ-033 exp 24, frac 1111 -> 0x7F; exp 0, frac 0000, trail 00 -> 0x01; isInf=1 -> 0x80; isZero=1 -> 0x00.
REQ-034 out_ready low for 5 cycles with in_valid high -> exactly 2 accepted, in_ready low, out_posit stable; out_ready high -> in-order drain, no bubble.
REQ-035 resetn asserted with both stages full -> out_valid low immediately; after release, first output matches first new input.
REQ-036 Randomized stream vs. reference model of REQ-021..026, random out_ready, ordering and values checked.
